uart_cmd_slv: RTL and testbench

//  DUT-side end of the host command link. Deserialises 3-byte UART commands from the host

---
 rtl/uart_cmd_slv.sv | 225 ++++++++++++++++++++++
 tb/tb_uart_cmd_slv.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_slv.sv
// uart_cmd_slv: device-side end of the host command link.
// Receives 3-byte 8N1 UART commands on RX and assembles them into a 24-bit word, and
// transmits 8-bit response bytes on TX. The RX and TX paths are fully independent.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   RX           serial input from host (asynchronous, idles high)
//   TX           serial output to host (idles high)
//   cmd          assembled command {opcode, data_hi, data_lo}
//   cmd_rdy      sticky: cmd holds a complete new command
//   clr_cmd_rdy  dispatcher acknowledge, clears cmd_rdy
//   resp         response byte to transmit
//   send_resp    one-cycle strobe: transmit resp
//   resp_sent    sticky: last response fully shifted out, including stop bit
module uart_cmd_slv #(
    parameter int unsigned BAUD_DIV = 2604  // clk cycles per bit, must be >= 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX,
    output logic        TX,
    output logic [23:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp,
    input  logic        send_resp,
    output logic        resp_sent
);

    localparam int unsigned CntW = $clog2(BAUD_DIV) + 1;
    localparam logic [CntW-1:0] BitEnd  = CntW'(BAUD_DIV - 1);
    localparam logic [CntW-1:0] HalfEnd = CntW'(BAUD_DIV / 2 - 1);

    typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;
    typedef enum logic {TxIdle, TxShift} tx_state_e;

    // ---------------- RX path ----------------
    logic            rx_ff1_q, rx_ff2_q, rx_ff3_q;
    rx_state_e       rx_state_q, rx_state_d;
    logic [CntW-1:0] rx_baud_q, rx_baud_d;
    logic [3:0]      rx_bit_q, rx_bit_d;
    logic [7:0]      rx_shift_q, rx_shift_d;
    logic [1:0]      byte_cnt_q, byte_cnt_d;
    logic [23:0]     cmd_q, cmd_d;
    logic            cmd_rdy_q, cmd_rdy_d;
    logic            rdy_set_q, rdy_set_d;
    logic            rx_start_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_ff1_q   <= 1'b1;
            rx_ff2_q   <= 1'b1;
            rx_ff3_q   <= 1'b1;
            rx_state_q <= RxIdle;
            rx_baud_q  <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            byte_cnt_q <= '0;
            cmd_q      <= '0;
            cmd_rdy_q  <= 1'b0;
            rdy_set_q  <= 1'b0;
        end else begin
            rx_ff1_q   <= RX;
            rx_ff2_q   <= rx_ff1_q;
            rx_ff3_q   <= rx_ff2_q;
            rx_state_q <= rx_state_d;
            rx_baud_q  <= rx_baud_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            byte_cnt_q <= byte_cnt_d;
            cmd_q      <= cmd_d;
            cmd_rdy_q  <= cmd_rdy_d;
            rdy_set_q  <= rdy_set_d;
        end
    end

    always_comb begin
        rx_state_d  = rx_state_q;
        rx_baud_d   = rx_baud_q;
        rx_bit_d    = rx_bit_q;
        rx_shift_d  = rx_shift_q;
        byte_cnt_d  = byte_cnt_q;
        cmd_d       = cmd_q;
        rdy_set_d   = 1'b0;
        rx_start_ok = 1'b0;
        unique case (rx_state_q)
            RxIdle: begin
                // rx_ff3_q is the previous synced sample: this is a falling edge
                if (!rx_ff2_q && rx_ff3_q) begin
                    rx_state_d = RxStart;
                    rx_baud_d  = '0;
                end
            end
            RxStart: begin
                if (rx_baud_q == HalfEnd) begin
                    rx_baud_d = '0;
                    rx_bit_d  = '0;
                    if (!rx_ff2_q) begin
                        rx_state_d  = RxData;
                        rx_start_ok = 1'b1;
                    end else begin
                        rx_state_d = RxIdle;  // glitch, not a start bit
                    end
                end else begin
                    rx_baud_d = rx_baud_q + CntW'(1);
                end
            end
            RxData: begin
                if (rx_baud_q == BitEnd) begin
                    rx_baud_d  = '0;
                    rx_shift_d = {rx_ff2_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 4'd1;
                    if (rx_bit_q == 4'd7) rx_state_d = RxStop;
                end else begin
                    rx_baud_d = rx_baud_q + CntW'(1);
                end
            end
            RxStop: begin
                if (rx_baud_q == BitEnd) begin
                    rx_baud_d  = '0;
                    rx_state_d = RxIdle;
                    if (rx_ff2_q) begin
                        unique case (byte_cnt_q)
                            2'd0: begin
                                cmd_d[23:16] = rx_shift_q;
                                byte_cnt_d   = 2'd1;
                            end
                            2'd1: begin
                                cmd_d[15:8] = rx_shift_q;
                                byte_cnt_d  = 2'd2;
                            end
                            default: begin
                                cmd_d[7:0] = rx_shift_q;
                                byte_cnt_d = 2'd0;
                                rdy_set_d  = 1'b1;
                            end
                        endcase
                    end else begin
                        byte_cnt_d = 2'd0;  // framing error: drop the partial command
                    end
                end else begin
                    rx_baud_d = rx_baud_q + CntW'(1);
                end
            end
            default: rx_state_d = RxIdle;
        endcase

        // Set has priority over both clear sources
        if (rdy_set_q) begin
            cmd_rdy_d = 1'b1;
        end else if (clr_cmd_rdy || (rx_start_ok && byte_cnt_q == 2'd0)) begin
            cmd_rdy_d = 1'b0;
        end else begin
            cmd_rdy_d = cmd_rdy_q;
        end
    end

    assign cmd     = cmd_q;
    assign cmd_rdy = cmd_rdy_q;

    // ---------------- TX path ----------------
    tx_state_e       tx_state_q, tx_state_d;
    logic [CntW-1:0] tx_baud_q, tx_baud_d;
    logic [3:0]      tx_bit_q, tx_bit_d;
    logic [9:0]      tx_shift_q, tx_shift_d;
    logic            resp_sent_q, resp_sent_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q  <= TxIdle;
            tx_baud_q   <= '0;
            tx_bit_q    <= '0;
            tx_shift_q  <= '1;
            resp_sent_q <= 1'b0;
        end else begin
            tx_state_q  <= tx_state_d;
            tx_baud_q   <= tx_baud_d;
            tx_bit_q    <= tx_bit_d;
            tx_shift_q  <= tx_shift_d;
            resp_sent_q <= resp_sent_d;
        end
    end

    always_comb begin
        tx_state_d  = tx_state_q;
        tx_baud_d   = tx_baud_q;
        tx_bit_d    = tx_bit_q;
        tx_shift_d  = tx_shift_q;
        resp_sent_d = resp_sent_q;
        unique case (tx_state_q)
            TxIdle: begin
                if (send_resp) begin
                    tx_shift_d  = {1'b1, resp, 1'b0};
                    tx_baud_d   = '0;
                    tx_bit_d    = '0;
                    resp_sent_d = 1'b0;
                    tx_state_d  = TxShift;
                end
            end
            TxShift: begin
                // send_resp is deliberately not looked at here
                if (tx_baud_q == BitEnd) begin
                    tx_baud_d  = '0;
                    tx_shift_d = {1'b1, tx_shift_q[9:1]};
                    tx_bit_d   = tx_bit_q + 4'd1;
                    if (tx_bit_q == 4'd9) begin
                        tx_state_d  = TxIdle;
                        resp_sent_d = 1'b1;
                    end
                end else begin
                    tx_baud_d = tx_baud_q + CntW'(1);
                end
            end
            default: tx_state_d = TxIdle;
        endcase
    end

    always_comb begin
        TX = (tx_state_q == TxShift) ? tx_shift_q[0] : 1'b1;
    end

    assign resp_sent = resp_sent_q;

endmodule

// File: tb/tb_uart_cmd_slv.sv
module tb_uart_cmd_slv;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx;
    logic        tx;
    logic [23:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic [7:0]  resp;
    logic        send_resp;
    logic        resp_sent;

    int checks   = 0;
    int failures = 0;

    uart_cmd_slv #(.BAUD_DIV(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .RX         (rx),
        .TX         (tx),
        .cmd        (cmd),
        .cmd_rdy    (cmd_rdy),
        .clr_cmd_rdy(clr_cmd_rdy),
        .resp       (resp),
        .send_resp  (send_resp),
        .resp_sent  (resp_sent)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Entered 1 time unit after a rising edge. Each bit lasts 16 clocks.
    // With lat set, checks cmd_rdy timing around the stop-bit sample (edge 155 of the frame).
    task automatic send_byte(input logic [7:0] b, input logic stop_ok, input logic lat,
                             input logic [23:0] exp_cmd);
        rx = 1'b0;
        repeat (16) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (16) @(posedge clk);
            #1;
        end
        rx = stop_ok;
        if (lat) begin
            repeat (11) @(posedge clk);
            #1;
            check_eq("cmd_at_stop", {8'h0, cmd}, {8'h0, exp_cmd});
            check_eq("rdy_before_lat", {31'h0, cmd_rdy}, 32'h0);
            @(posedge clk);
            #1;
            check_eq("rdy_after_lat", {31'h0, cmd_rdy}, 32'h1);
            repeat (4) @(posedge clk);
            #1;
        end else begin
            repeat (16) @(posedge clk);
            #1;
        end
        rx = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [23:0] c, input logic lat);
        send_byte(c[23:16], 1'b1, 1'b0, 24'h0);
        send_byte(c[15:8], 1'b1, 1'b0, 24'h0);
        send_byte(c[7:0], 1'b1, lat, c);
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Strobe send_resp and check each TX bit at its centre; optionally a second strobe mid-frame.
    task automatic tx_frame(input logic [9:0] exp_frame, input logic [7:0] b, input logic mid);
        logic [7:0] rcv;
        rcv = 8'h0;
        resp = b;
        send_resp = 1'b1;
        @(posedge clk);
        #1;
        send_resp = 1'b0;
        check_eq("sent_clr", {31'h0, resp_sent}, 32'h0);
        for (int k = 0; k < 10; k++) begin
            repeat (8) @(posedge clk);
            #1;
            check_eq("tx_bit", {31'h0, tx}, {31'h0, exp_frame[k]});
            if (k >= 1 && k <= 8) rcv[k-1] = tx;
            if (mid && k == 4) begin
                resp = 8'h00;
                send_resp = 1'b1;
                @(posedge clk);
                #1;
                send_resp = 1'b0;
                repeat (7) @(posedge clk);
                #1;
            end else if (k == 9) begin
                repeat (7) @(posedge clk);
                #1;
                check_eq("sent_at_159", {31'h0, resp_sent}, 32'h0);
                @(posedge clk);
                #1;
                check_eq("sent_at_160", {31'h0, resp_sent}, 32'h1);
                check_eq("tx_idle", {31'h0, tx}, 32'h1);
            end else begin
                repeat (8) @(posedge clk);
                #1;
            end
        end
        check_eq("resp_rcv", {24'h0, rcv}, {24'h0, b});
    endtask

    initial begin
        rst_n = 1'b0;
        rx = 1'b1;
        clr_cmd_rdy = 1'b0;
        resp = 8'h00;
        send_resp = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_tx", {31'h0, tx}, 32'h1);
        check_eq("rst_cmd", {8'h0, cmd}, 32'h0);
        check_eq("rst_rdy", {31'h0, cmd_rdy}, 32'h0);
        check_eq("rst_sent", {31'h0, resp_sent}, 32'h0);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // 1: basic command with cmd_rdy latency
        send_cmd(24'h03002E, 1'b1);
        check_eq("t1_cmd", {8'h0, cmd}, 32'h0003002E);
        check_eq("t1_rdy", {31'h0, cmd_rdy}, 32'h1);

        // 2: acknowledge, then a new command without acknowledge
        clr_cmd_rdy = 1'b1;
        @(posedge clk);
        #1;
        clr_cmd_rdy = 1'b0;
        check_eq("t2_clr_rdy", {31'h0, cmd_rdy}, 32'h0);
        check_eq("t2_clr_cmd", {8'h0, cmd}, 32'h0003002E);
        send_cmd(24'h03002E, 1'b0);
        send_byte(8'h08, 1'b1, 1'b0, 24'h0);
        check_eq("t2_b0_rdy", {31'h0, cmd_rdy}, 32'h0);
        check_eq("t2_b0_cmd", {8'h0, cmd}, 32'h0008002E);
        send_byte(8'h00, 1'b1, 1'b0, 24'h0);
        send_byte(8'h00, 1'b1, 1'b0, 24'h0);
        repeat (2) @(posedge clk);
        #1;
        check_eq("t2_cmd", {8'h0, cmd}, 32'h00080000);
        check_eq("t2_rdy", {31'h0, cmd_rdy}, 32'h1);

        // 3: response A5, second strobe mid-frame ignored
        tx_frame(10'b11_0100_1010, 8'hA5, 1'b1);

        // 4: framing error on byte1, then a clean command
        send_byte(8'h07, 1'b1, 1'b0, 24'h0);
        send_byte(8'h11, 1'b0, 1'b0, 24'h0);
        repeat (20) @(posedge clk);
        #1;
        check_eq("t4_ferr_rdy", {31'h0, cmd_rdy}, 32'h0);
        check_eq("t4_ferr_cmd", {8'h0, cmd}, 32'h00070000);
        send_cmd(24'h050002, 1'b0);
        check_eq("t4_cmd", {8'h0, cmd}, 32'h00050002);
        check_eq("t4_rdy", {31'h0, cmd_rdy}, 32'h1);

        // 5: 4-clock low glitch
        rx = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (200) @(posedge clk);
        #1;
        check_eq("t5_cmd", {8'h0, cmd}, 32'h00050002);
        check_eq("t5_rdy", {31'h0, cmd_rdy}, 32'h1);

        // 6: reset mid-byte1 and mid-TX frame
        send_byte(8'h09, 1'b1, 1'b0, 24'h0);
        check_eq("t6_b0_cmd", {8'h0, cmd}, 32'h00090002);
        resp = 8'h00;
        send_resp = 1'b1;
        @(posedge clk);
        #1;
        send_resp = 1'b0;
        rx = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check_eq("t6_tx_busy", {31'h0, tx}, 32'h0);
        rst_n = 1'b0;
        #1;
        check_eq("t6_rst_tx", {31'h0, tx}, 32'h1);
        check_eq("t6_rst_cmd", {8'h0, cmd}, 32'h0);
        check_eq("t6_rst_rdy", {31'h0, cmd_rdy}, 32'h0);
        rx = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        send_cmd(24'h020000, 1'b0);
        check_eq("t6_cmd", {8'h0, cmd}, 32'h00020000);
        check_eq("t6_rdy", {31'h0, cmd_rdy}, 32'h1);
        check_eq("t6_tx_idle", {31'h0, tx}, 32'h1);

        // Full duplex: command and response overlapped
        fork
            send_cmd(24'h03002E, 1'b1);
            tx_frame(10'b11_0100_1010, 8'hA5, 1'b0);
        join
        check_eq("fd_cmd", {8'h0, cmd}, 32'h0003002E);
        check_eq("fd_rdy", {31'h0, cmd_rdy}, 32'h1);
        check_eq("fd_sent", {31'h0, resp_sent}, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
